// File: rtl/seq_add_pkg.sv
// Shared types and defaults for the chunk-serial adder/subtractor.
package seq_add_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunk_add.sv
// CHUNK-bit combinational adder slice; c_msb is the carry into the top bit.
module chunk_add
  import seq_add_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    // Carry into the top bit falls out of the top-bit sum identity.
    c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];
  end

endmodule

// File: rtl/seq_add_sub.sv
// Chunk-serial add/subtract: one CHUNK-bit slice per clock, valid/ready on both sides.
module seq_add_sub
  import seq_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             OF,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("seq_add_sub: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_out_q, of_q, in_ready_q, out_valid_q;

  logic [CHUNK-1:0] c_s;
  logic             c_co, c_msb;
  logic             last;

  // Operands shift down each BUSY cycle so the slice adder always sees chunk 0.
  chunk_add #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .cin   (carry_q),
    .s     (c_s),
    .cout  (c_co),
    .c_msb (c_msb)
  );

  assign last = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      carry_out_q <= 1'b0;
      of_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= A;
            b_q        <= B ^ {WIDTH{Sub}};
            carry_q    <= Sub;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          // New slice enters at the top; after N cycles chunk i sits in place i.
          sum_q   <= (sum_q >> CHUNK) | (WIDTH'(c_s) << (WIDTH - CHUNK));
          carry_q <= c_co;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            carry_out_q <= c_co;
            of_q        <= c_msb ^ c_co;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Carry     = carry_out_q;
  assign OF        = of_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub: three configurations against an arithmetic reference model.
module tb_seq_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  iv, ordy, sb, irdy, ovld, cy, ofl;
  logic [63:0] a_in [3];
  logic [63:0] b_in [3];
  logic [31:0] s0;
  logic [15:0] s1;
  logic [63:0] s2;

  int checks = 0;
  int errors = 0;

  seq_add_sub #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst(rst), .A(a_in[0][31:0]), .B(b_in[0][31:0]), .Sub(sb[0]),
    .in_valid(iv[0]), .in_ready(irdy[0]), .Sum(s0), .Carry(cy[0]), .OF(ofl[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]));

  seq_add_sub #(.WIDTH(16), .CHUNK(16)) u1 (
    .clk(clk), .rst(rst), .A(a_in[1][15:0]), .B(b_in[1][15:0]), .Sub(sb[1]),
    .in_valid(iv[1]), .in_ready(irdy[1]), .Sum(s1), .Carry(cy[1]), .OF(ofl[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1]));

  seq_add_sub #(.WIDTH(64), .CHUNK(4)) u2 (
    .clk(clk), .rst(rst), .A(a_in[2]), .B(b_in[2]), .Sub(sb[2]),
    .in_valid(iv[2]), .in_ready(irdy[2]), .Sum(s2), .Carry(cy[2]), .OF(ofl[2]),
    .out_valid(ovld[2]), .out_ready(ordy[2]));

  function automatic int wid(input int i);
    return (i == 0) ? 32 : (i == 1) ? 16 : 64;
  endfunction

  function automatic int nch(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 16;
  endfunction

  function automatic logic [63:0] mask(input int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] sum_of(input int i);
    return (i == 0) ? {32'd0, s0} : (i == 1) ? {48'd0, s1} : s2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum/difference for Sum and Carry, signed range test for OF.
  task automatic ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                           input logic s, output logic [63:0] es, output logic ec,
                           output logic eo);
    logic signed [67:0] ua, ub, ur, sa, sbv, sr, lim;
    ua = {4'b0, a & mask(w)};
    ub = {4'b0, b & mask(w)};
    ur = s ? ua - ub : ua + ub;
    es = ur[63:0] & mask(w);
    ec = s ? (ua >= ub) : (ur >= (68'sd1 <<< w));
    sa  = a[w-1] ? ua - (68'sd1 <<< w) : ua;
    sbv = b[w-1] ? ub - (68'sd1 <<< w) : ub;
    sr  = s ? sa - sbv : sa + sbv;
    lim = 68'sd1 <<< (w - 1);
    eo  = (sr >= lim) || (sr < -lim);
  endtask

  task automatic scramble(input int i);
    a_in[i] = {$urandom, $urandom};
    b_in[i] = {$urandom, $urandom};
    sb[i]   = 1'($urandom);
  endtask

  // One operation: accept, scramble inputs while busy, measure latency,
  // hold in DONE for `hold` cycles (optionally with a competing in_valid), drain.
  task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input int hold, input logic press,
                       output logic [63:0] rs, output logic rc, output logic ro,
                       output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", {63'd0, irdy[i]}, 64'd1);
    iv[i] = 1'b1; a_in[i] = a; b_in[i] = b; sb[i] = s;
    @(posedge clk);
    @(negedge clk);
    iv[i] = 1'b0;
    scramble(i);
    lat = 1;
    while (!ovld[i] && lat < 40) begin
      @(negedge clk);
      scramble(i);
      lat++;
    end
    rs = sum_of(i); rc = cy[i]; ro = ofl[i];
    for (int k = 0; k < hold; k++) begin
      if (press) iv[i] = 1'b1;
      @(negedge clk);
      scramble(i);
      chk("hold_sum", sum_of(i), rs);
      chk("hold_flags", {61'd0, cy[i], ofl[i], ovld[i]}, {61'd0, rc, ro, 1'b1});
      chk("hold_in_ready", {63'd0, irdy[i]}, 64'd0);
    end
    ordy[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[i] = 1'b0;
    chk("drain_out_valid", {63'd0, ovld[i]}, 64'd0);
    chk("drain_in_ready", {63'd0, irdy[i]}, 64'd1);
    iv[i] = 1'b0;
  endtask

  initial begin
    logic [63:0] rs, es, ra, rb;
    logic        rc, ro, ec, eo, rsub, seen;
    int          lat;

    rst = 1'b1; iv = '0; ordy = '0; sb = '0;
    for (int i = 0; i < 3; i++) begin a_in[i] = '0; b_in[i] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("reset_ready_valid", {62'd0, irdy[i], ovld[i]}, 64'd2);
      chk("reset_sum", sum_of(i), 64'd0);
      chk("reset_flags", {62'd0, cy[i], ofl[i]}, 64'd0);
    end

    // Directed corner vectors for the default configuration.
    issue(0, 64'h7FFFFFFF, 64'h1, 1'b0, 0, 1'b0, rs, rc, ro, lat);
    chk("pos_ovf_sum", rs, 64'h80000000);
    chk("pos_ovf_flags", {62'd0, rc, ro}, 64'b01);
    chk("pos_ovf_latency", 64'(lat), 64'd5);

    issue(0, 64'hFFFFFFFF, 64'h1, 1'b0, 0, 1'b0, rs, rc, ro, lat);
    chk("ripple_sum", rs, 64'h0);
    chk("ripple_flags", {62'd0, rc, ro}, 64'b10);

    issue(0, 64'h80000000, 64'h1, 1'b1, 0, 1'b0, rs, rc, ro, lat);
    chk("neg_ovf_sum", rs, 64'h7FFFFFFF);
    chk("neg_ovf_flags", {62'd0, rc, ro}, 64'b11);

    issue(0, 64'h0, 64'h1, 1'b1, 0, 1'b0, rs, rc, ro, lat);
    chk("borrow_sum", rs, 64'hFFFFFFFF);
    chk("borrow_flags", {62'd0, rc, ro}, 64'b00);

    // Backpressure with a competing request held through the DONE exit.
    issue(0, 64'h12345678, 64'h11111111, 1'b0, 3, 1'b1, rs, rc, ro, lat);
    chk("bp_sum", rs, 64'h23456789);
    issue(0, 64'h00000005, 64'h00000003, 1'b1, 0, 1'b0, rs, rc, ro, lat);
    chk("after_bp_sum", rs, 64'h2);
    chk("after_bp_flags", {62'd0, rc, ro}, 64'b10);

    // Reset during the second BUSY cycle aborts the operation.
    @(negedge clk);
    iv[0] = 1'b1; a_in[0] = 64'hAAAA5555; b_in[0] = 64'h1234; sb[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready_valid", {62'd0, irdy[0], ovld[0]}, 64'd2);
    chk("abort_sum", sum_of(0), 64'd0);
    chk("abort_flags", {62'd0, cy[0], ofl[0]}, 64'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ovld[0]) seen = 1'b1;
    end
    chk("abort_no_result", {63'd0, seen}, 64'd0);

    // Randomized operations on all three configurations.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 12; n++) begin
        ra = {$urandom, $urandom} & mask(wid(i));
        rb = {$urandom, $urandom} & mask(wid(i));
        if (n == 0) begin ra = mask(wid(i)); rb = 64'd1; end
        rsub = 1'($urandom);
        issue(i, ra, rb, rsub, int'($urandom_range(0, 2)), 1'($urandom), rs, rc, ro, lat);
        ref_model(wid(i), ra, rb, rsub, es, ec, eo);
        chk("rand_sum", rs, es);
        chk("rand_flags", {62'd0, rc, ro}, {62'd0, ec, eo});
        chk("rand_latency", 64'(lat), 64'(nch(i) + 1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_add_sub.md
SEQ_ADD_SUB -- requirements
Module: seq_add_sub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 8, bits summed per clock; WIDTH % CHUNK != 0 SHALL be an elaboration error; N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 A  input  WIDTH  operand A, two's complement or unsigned.
REQ-006 B  input  WIDTH  operand B.
REQ-007 Sub  input  1  mode: 0 = A+B, 1 = A-B.
REQ-008 in_valid  input  1  operands and Sub are valid.
REQ-009 in_ready  output  1  block can accept an operation.
REQ-010 Sum  output  WIDTH  result, low WIDTH bits.
REQ-011 Carry  output  1  carry-out of MSB (for Sub: 1 = no borrow).
REQ-012 OF  output  1  signed overflow.
REQ-013 out_valid  output  1  Sum/Carry/OF are valid.
REQ-014 out_ready  input  1  consumer accepts the result.

Function
REQ-015 FSM states: IDLE, BUSY, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE: on in_valid=1, capture A, B^{WIDTH{Sub}}, carry-in = Sub; clear chunk counter; go to BUSY.
REQ-018 BUSY: each cycle add chunk i (bits i*CHUNK+CHUNK-1 .. i*CHUNK) with the registered carry, write into Sum chunk i, register carry-out, increment counter.
REQ-019 After chunk N-1 is processed, go to DONE; operation accepted in cycle t SHALL show out_valid=1 first in cycle t+N+1 (5 cycles for defaults).
REQ-020 Carry = carry-out of chunk N-1; OF = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-021 DONE: Sum, Carry, OF, out_valid held stable until out_ready=1; on out_valid&&out_ready go to IDLE.
REQ-022 in_valid while in_ready=0 SHALL be ignored; no operand capture, no queueing.
REQ-023 Operand inputs changing during BUSY SHALL NOT affect the result.
REQ-024 No accept in the DONE-exit cycle; minimum issue interval N+2 cycles with out_ready held high.
REQ-025 N=1 (CHUNK=WIDTH) SHALL work: one BUSY cycle.
REQ-026 Sum chunks not yet computed in BUSY are don't-care; only DONE values are architectural.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, in_ready=1, out_valid=0, Sum=0, Carry=0, OF=0, counter=0, regardless of state.
REQ-028 rst asserted in BUSY or DONE SHALL discard the in-flight operation; no out_valid results from it.
REQ-029 rst has priority over in_valid and out_ready in the same cycle.

Structure
REQ-030 Package seq_add_pkg SHALL hold the FSM state enum and default WIDTH/CHUNK constants.
REQ-031 One sub-module chunk_add SHALL be used: CHUNK-bit combinational adder, inputs a, b, cin, outputs s, cout, c_msb (carry into top bit).
REQ-032 Counter width SHALL be $clog2(N) with a minimum of 1 bit; registered carry is 1 bit; no other arithmetic outside chunk_add.

Verification
REQ-033 Sub=0, A=32'h7FFFFFFF, B=32'h00000001 -> Sum=32'h80000000, Carry=0, OF=1, out_valid in cycle t+5.
REQ-034 Sub=0, A=32'hFFFFFFFF, B=32'h00000001 -> Sum=0, Carry=1, OF=0 (carry ripples through all 4 chunks).
REQ-035 Sub=1, A=32'h80000000, B=1 -> Sum=32'h7FFFFFFF, Carry=1, OF=1; Sub=1, A=0, B=1 -> Sum=32'hFFFFFFFF, Carry=0, OF=0.
REQ-036 Backpressure: out_ready=0 for 3 cycles in DONE with new in_valid=1 -> outputs stable, in_ready=0, new operands not captured; result drains on out_ready=1, then IDLE.
REQ-037 rst=1 in 2nd BUSY cycle -> next cycle IDLE, in_ready=1, out_valid=0, Sum/Carry/OF=0; no result from the aborted operation ever appears.
REQ-038 Random A/B/Sub for WIDTH=32/CHUNK=8, WIDTH=16/CHUNK=16 and WIDTH=64/CHUNK=4 -> Sum/Carry/OF match the reference model; latency is N+1.
